// File: rtl/adc_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_CH
// free-running ADC channels, with per-channel hold registers, drop
// accounting and FIFO clear sequencing.
module adc_fifo_wr_arbiter #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SAMPLE_WIDTH = 48,
  parameter int unsigned DATA_WIDTH   = 56,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_CH-1:0]              ch_strobe,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_data,
  input  logic                           clear_req,
  input  logic                           ovf_clr,
  input  logic                           fifo_full,
  output logic                           adc_wr_en,
  output logic [DATA_WIDTH-1:0]          adc_data,
  output logic                           fifo_clear,
  output logic [NUM_CH-1:0]              ch_overflow,
  output logic [NUM_CH*CNT_WIDTH-1:0]    drop_cnt,
  output logic                           busy
);

  localparam int unsigned TAG_W = DATA_WIDTH - SAMPLE_WIDTH;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]       r_hold_valid;
  logic [SAMPLE_WIDTH-1:0] r_hold_data [NUM_CH];
  logic [IDX_W-1:0]        r_last_grant;
  logic                    r_clear_req_d;
  logic                    r_fifo_clear;
  logic [NUM_CH-1:0]       r_ch_overflow;
  logic [CNT_WIDTH-1:0]    r_drop_cnt [NUM_CH];

  logic                    w_write_ok;
  logic [IDX_W-1:0]        w_grant;
  logic                    w_found;
  logic [IDX_W:0]          w_sum;
  logic [NUM_CH-1:0]       w_wr_vec;
  logic [NUM_CH-1:0]       w_capture;
  logic [NUM_CH-1:0]       w_drop;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_sum = {1'b0, r_last_grant} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_CH)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_CH);
      end
      if (!w_found && r_hold_valid[w_sum[IDX_W-1:0]]) begin
        w_grant = w_sum[IDX_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  // Write qualification, one-hot write vector and FIFO word
  always_comb begin
    w_write_ok = enable & ~fifo_full & ~clear_req & ~r_fifo_clear & (|r_hold_valid);
    w_wr_vec   = '0;
    adc_data   = '0;
    if (w_write_ok) begin
      w_wr_vec = NUM_CH'(1) << w_grant;
      adc_data = {TAG_W'(w_grant), r_hold_data[w_grant]};
    end
  end

  // Per-channel capture vs. drop decision; a clear discards strobes silently
  always_comb begin
    w_capture = '0;
    w_drop    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_capture[i] = ch_strobe[i] & ~clear_req & (~r_hold_valid[i] | w_wr_vec[i]);
      w_drop[i]    = ch_strobe[i] & ~clear_req & r_hold_valid[i] & ~w_wr_vec[i];
    end
  end

  // Hold-valid bits, grant pointer and single-pulse FIFO clear on clear_req rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_valid  <= '0;
      r_last_grant  <= LAST_IDX;
      r_clear_req_d <= 1'b0;
      r_fifo_clear  <= 1'b0;
    end else begin
      if (clear_req) begin
        r_hold_valid <= '0;
        r_last_grant <= LAST_IDX;
      end else begin
        r_hold_valid <= (r_hold_valid & ~w_wr_vec) | w_capture;
        if (w_write_ok) begin
          r_last_grant <= w_grant;
        end
      end
      r_clear_req_d <= clear_req;
      r_fifo_clear  <= clear_req & ~r_clear_req_d;
    end
  end

  // Sample holding registers; contents only matter while hold_valid is set
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_capture[i]) begin
        r_hold_data[i] <= ch_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  // Sticky overflow flags and saturating drop counters; a same-cycle drop beats ovf_clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_overflow <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_drop_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ovf_clr) begin
          r_ch_overflow[i] <= w_drop[i];
          r_drop_cnt[i]    <= w_drop[i] ? CNT_WIDTH'(1) : '0;
        end else if (w_drop[i]) begin
          r_ch_overflow[i] <= 1'b1;
          if (r_drop_cnt[i] != '1) begin
            r_drop_cnt[i] <= r_drop_cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Flatten counters onto the output bus
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign drop_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_drop_cnt[g];
  end

  assign adc_wr_en   = w_write_ok;
  assign fifo_clear  = r_fifo_clear;
  assign ch_overflow = r_ch_overflow;
  assign busy        = |r_hold_valid;

endmodule

// File: tb/tb_adc_fifo_wr_arbiter.sv
// Directed scoreboard bench for adc_fifo_wr_arbiter (default parameters).
module tb_adc_fifo_wr_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SW     = 48;
  localparam int unsigned DW     = 56;
  localparam int unsigned CW     = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic [NUM_CH-1:0]    ch_strobe;
  logic [NUM_CH*SW-1:0] ch_data;
  logic                 clear_req;
  logic                 ovf_clr;
  logic                 fifo_full;
  logic                 adc_wr_en;
  logic [DW-1:0]        adc_data;
  logic                 fifo_clear;
  logic [NUM_CH-1:0]    ch_overflow;
  logic [NUM_CH*CW-1:0] drop_cnt;
  logic                 busy;

  int n_vec  = 0;
  int n_fail = 0;
  logic [DW-1:0] sb[$];

  adc_fifo_wr_arbiter #(
    .NUM_CH(NUM_CH), .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_strobe(ch_strobe),
    .ch_data(ch_data), .clear_req(clear_req), .ovf_clr(ovf_clr),
    .fifo_full(fifo_full), .adc_wr_en(adc_wr_en), .adc_data(adc_data),
    .fifo_clear(fifo_clear), .ch_overflow(ch_overflow), .drop_cnt(drop_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [SW-1:0] val);
    ch_data[ch*SW +: SW] = val;
  endtask

  task automatic push(input int ch, input logic [SW-1:0] val);
    sb.push_back({8'(ch), val});
  endtask

  task automatic chk_wr(input string tag);
    logic [DW-1:0] exp;
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 56'hFF_DEAD_DEAD_DEAD;
    chk({tag, "_en"}, 64'(adc_wr_en), 64'd1);
    chk({tag, "_data"}, 64'(adc_data), 64'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int order [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; enable = 1'b1; ch_strobe = '0; ch_data = '0;
    clear_req = 1'b0; ovf_clr = 1'b0; fifo_full = 1'b0;

    // Reset state
    tick(); tick();
    mid();
    chk("rst_wr_en", 64'(adc_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_clear", 64'(fifo_clear), 64'd0);
    chk("rst_ovf", 64'(ch_overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single strobe on ch2, one-cycle latency to the write
    ch_strobe = 4'b0100; set_ch(2, 48'h0000_1234_5678);
    mid();
    chk("t1_pre_wr", 64'(adc_wr_en), 64'd0);
    tick();
    ch_strobe = '0;
    sb.push_back(56'h02_0000_1234_5678);
    mid();
    chk_wr("t1_wr");
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    mid();
    chk("t1_post_wr", 64'(adc_wr_en), 64'd0);
    chk("t1_post_busy", 64'(busy), 64'd0);
    tick();

    // Four simultaneous strobes, written back-to-back in channel order from reset
    do_reset();
    ch_strobe = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 48'(32'hA0 + c));
      push(c, 48'(32'hA0 + c));
    end
    mid();
    chk("t2_pre_wr", 64'(adc_wr_en), 64'd0);
    tick();
    ch_strobe = '0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk_wr($sformatf("t2_wr%0d", k));
      tick();
    end
    mid();
    chk("t2_post_wr", 64'(adc_wr_en), 64'd0);
    chk("t2_post_busy", 64'(busy), 64'd0);
    tick();

    // FIFO full: three strobes on ch1 -> first held, two dropped
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ch_strobe = 4'b0010; set_ch(1, 48'(32'h111 * (k + 1)));
      mid();
      chk($sformatf("t3_stall_wr%0d", k), 64'(adc_wr_en), 64'd0);
      tick();
    end
    ch_strobe = '0;
    mid();
    chk("t3_drop_cnt", 64'(drop_cnt), 64'h0000_0200);
    chk("t3_ovf", 64'(ch_overflow), 64'b0010);
    chk("t3_busy", 64'(busy), 64'd1);
    tick();
    fifo_full = 1'b0;
    push(1, 48'h111);
    mid();
    chk_wr("t3_release");
    tick();
    mid();
    chk("t3_only_one", 64'(adc_wr_en), 64'd0);
    tick();

    // All channels kept valid: fair rotation starting after ch1
    ch_strobe = 4'b1111;
    for (int c = 0; c < 4; c++) set_ch(c, 48'(32'hC000 + c));
    mid();
    chk("t4_fill_wr", 64'(adc_wr_en), 64'd0);
    tick();
    for (int c = 0; c < 4; c++) push(order[c], 48'(32'hC000 + order[c]));
    for (int k = 0; k < 8; k++) begin
      ch_strobe = 4'(1 << order[k]);
      set_ch(order[k], 48'(32'hC000 + 16 * (k + 1) + order[k]));
      push(order[k], 48'(32'hC000 + 16 * (k + 1) + order[k]));
      mid();
      chk_wr($sformatf("t4_rr%0d", k));
      tick();
    end
    ch_strobe = '0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk_wr($sformatf("t4_drain%0d", k));
      tick();
    end
    mid();
    chk("t4_no_drops", 64'(drop_cnt), 64'h0000_0200);
    chk("t4_idle", 64'(busy), 64'd0);
    tick();

    // Clear sequence with ch0 and ch3 held
    enable = 1'b0;
    ch_strobe = 4'b1001; set_ch(0, 48'hD0); set_ch(3, 48'hD3);
    mid();
    chk("t5_hold_wr", 64'(adc_wr_en), 64'd0);
    tick();
    ch_strobe = '0;
    mid();
    chk("t5_held_busy", 64'(busy), 64'd1);
    chk("t5_disabled_wr", 64'(adc_wr_en), 64'd0);
    tick();
    enable = 1'b1; clear_req = 1'b1; ch_strobe = 4'b1011;
    mid();
    chk("t5_clrreq_wr", 64'(adc_wr_en), 64'd0);
    tick();
    clear_req = 1'b0; ch_strobe = '0;
    mid();
    chk("t5_fifo_clear", 64'(fifo_clear), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_clr_wr", 64'(adc_wr_en), 64'd0);
    chk("t5_drop_cnt", 64'(drop_cnt), 64'h0000_0200);
    chk("t5_ovf", 64'(ch_overflow), 64'b0010);
    tick();
    clear_req = 1'b1;
    mid();
    chk("t5_pulse_end", 64'(fifo_clear), 64'd0);
    tick();
    mid();
    chk("t5_held_pulse", 64'(fifo_clear), 64'd1);
    tick();
    mid();
    chk("t5_held_once", 64'(fifo_clear), 64'd0);
    tick();
    clear_req = 1'b0;
    mid();
    chk("t5_released", 64'(fifo_clear), 64'd0);
    tick();
    // Pointer reset by the clear: ch0 wins over ch3
    ch_strobe = 4'b1001; set_ch(0, 48'hE0); set_ch(3, 48'hE3);
    push(0, 48'hE0); push(3, 48'hE3);
    tick();
    ch_strobe = '0;
    mid();
    chk_wr("t5_ptr_a");
    tick();
    mid();
    chk_wr("t5_ptr_b");
    tick();

    // 260 drops on ch0 saturate the counter at 255
    fifo_full = 1'b1;
    set_ch(0, 48'hF0);
    for (int k = 0; k < 261; k++) begin
      ch_strobe = 4'b0001;
      tick();
    end
    ch_strobe = '0;
    mid();
    chk("t6_sat", 64'(drop_cnt), 64'h0000_02FF);
    chk("t6_ovf", 64'(ch_overflow), 64'b0011);
    chk("t6_stall_wr", 64'(adc_wr_en), 64'd0);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    mid();
    chk("t6_clr_cnt", 64'(drop_cnt), 64'd0);
    chk("t6_clr_ovf", 64'(ch_overflow), 64'd0);
    tick();
    ovf_clr = 1'b1; ch_strobe = 4'b0001;
    tick();
    ovf_clr = 1'b0; ch_strobe = '0;
    mid();
    chk("t6_drop_wins_cnt", 64'(drop_cnt), 64'h0000_0001);
    chk("t6_drop_wins_ovf", 64'(ch_overflow), 64'b0001);
    chk("t6_busy", 64'(busy), 64'd1);
    tick();

    // Reset mid-stall discards the held sample
    rst_n = 1'b0;
    tick();
    mid();
    chk("t7_wr_en", 64'(adc_wr_en), 64'd0);
    chk("t7_data", 64'(adc_data), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_fifo_clear", 64'(fifo_clear), 64'd0);
    chk("t7_ovf", 64'(ch_overflow), 64'd0);
    chk("t7_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1; fifo_full = 1'b0;
    tick();
    mid();
    chk("t7_no_stale_wr", 64'(adc_wr_en), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
